// File: rtl/if_id_skid_stage.sv
// IF/ID stage register with an in-order skid FIFO, stall, flush and a valid bit; one-cycle latency.
// Backpressure: in_ready drops only when the skid FIFO is full. Optional counters: IF_ID_SKID_PERF_EN.
module if_id_skid_stage #(
  parameter int              XLEN       = 32,
  parameter int              ILEN       = 32,
  parameter int              SKID_DEPTH = 2,
  parameter logic [ILEN-1:0] NOP_INS    = ILEN'(32'h0000_0013),
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h0000_0000)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [XLEN-1:0]               in_pc,
  input  logic [ILEN-1:0]               in_ins,
  output logic                          in_ready,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [XLEN-1:0]               out_pc,
  output logic [ILEN-1:0]               out_ins,
`ifdef IF_ID_SKID_PERF_EN
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   bubble_cycles,
  output logic [15:0]                   flush_count,
`endif
  output logic [$clog2(SKID_DEPTH):0]   skid_count
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(SKID_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(SKID_DEPTH - 1);

  logic [XLEN-1:0] pc_mem  [SKID_DEPTH];
  logic [ILEN-1:0] ins_mem [SKID_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            push;

  // Non-power-of-two-safe wrap; also keeps depth 1 well defined.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  assign in_ready = (skid_count != DEPTH_C);
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_pc     <= RESET_PC;
      out_ins    <= NOP_INS;
      skid_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ins    <= NOP_INS;
      skid_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else if (stall) begin
      if (push) begin
        pc_mem[wr_ptr]  <= in_pc;
        ins_mem[wr_ptr] <= in_ins;
        wr_ptr          <= ptr_inc(wr_ptr);
        skid_count      <= skid_count + CW'(1);
      end
    end else if (skid_count != '0) begin
      // Queued pairs go first; a new push lands behind them to keep order.
      out_valid <= 1'b1;
      out_pc    <= pc_mem[rd_ptr];
      out_ins   <= ins_mem[rd_ptr];
      rd_ptr    <= ptr_inc(rd_ptr);
      if (push) begin
        pc_mem[wr_ptr]  <= in_pc;
        ins_mem[wr_ptr] <= in_ins;
        wr_ptr          <= ptr_inc(wr_ptr);
      end else begin
        skid_count <= skid_count - CW'(1);
      end
    end else if (push) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_ins   <= in_ins;
    end else begin
      out_valid <= 1'b0;
      out_ins   <= NOP_INS;
    end
  end

`ifdef IF_ID_SKID_PERF_EN
  // Observation-only counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
      flush_count   <= '0;
    end else begin
      if (stall && out_valid && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (!out_valid && (bubble_cycles != '1))        bubble_cycles <= bubble_cycles + 32'd1;
      if (flush && (flush_count != '1))               flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: depth-2 instance for the main scenarios, depth-4 instance for pointer wrap.
module tb_if_id_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] in_pc = '0, in_ins = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_ins;
  logic [1:0]  skid_count;

  logic        in_valid2 = 1'b0, stall2 = 1'b0;
  logic [31:0] in_pc2 = '0, in_ins2 = '0;
  logic        in_ready2, out_valid2;
  logic [31:0] out_pc2, out_ins2;
  logic [2:0]  skid_count2;

`ifdef IF_ID_SKID_PERF_EN
  logic [31:0] stall_cycles, bubble_cycles, stall_cycles2, bubble_cycles2;
  logic [15:0] flush_count, flush_count2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_id_skid_stage #(.SKID_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc), .in_ins(in_ins),
    .in_ready(in_ready), .stall(stall), .flush(flush), .out_valid(out_valid),
    .out_pc(out_pc), .out_ins(out_ins),
`ifdef IF_ID_SKID_PERF_EN
    .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles), .flush_count(flush_count),
`endif
    .skid_count(skid_count)
  );

  if_id_skid_stage #(.SKID_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_pc(in_pc2), .in_ins(in_ins2),
    .in_ready(in_ready2), .stall(stall2), .flush(1'b0), .out_valid(out_valid2),
    .out_pc(out_pc2), .out_ins(out_ins2),
`ifdef IF_ID_SKID_PERF_EN
    .stall_cycles(stall_cycles2), .bubble_cycles(bubble_cycles2), .flush_count(flush_count2),
`endif
    .skid_count(skid_count2)
  );

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return {16'hCAFE, pc[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_ins   = ins_of(pc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h100);
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got=%h exp=00000000", out_pc); end
    checks++; if (out_ins !== 32'h13) begin errors++; $display("FAIL reset_out_ins got=%h exp=00000013", out_ins); end
    checks++; if (skid_count !== 2'd0) begin errors++; $display("FAIL reset_skid_count got=%0d exp=0", skid_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    step();
    checks++; if (out_pc !== 32'h100 || out_valid !== 1'b1 || out_ins !== ins_of(32'h100)) begin
      errors++; $display("FAIL first_release got pc=%h v=%b ins=%h exp pc=00000100 v=1 ins=%h", out_pc, out_valid, out_ins, ins_of(32'h100)); end
  endtask

  task automatic test_stall_queue();
    stall = 1'b1;
    drive(1'b1, 32'h104); step();
    checks++; if (skid_count !== 2'd1 || out_pc !== 32'h100) begin
      errors++; $display("FAIL stall_push1 got cnt=%0d pc=%h exp cnt=1 pc=00000100", skid_count, out_pc); end
    drive(1'b1, 32'h108); step();
    checks++; if (skid_count !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h100) begin
      errors++; $display("FAIL stall_push2 got cnt=%0d rdy=%b pc=%h exp cnt=2 rdy=0 pc=00000100", skid_count, in_ready, out_pc); end
    drive(1'b1, 32'h10C); step();
    checks++; if (skid_count !== 2'd2 || out_pc !== 32'h100 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_full got cnt=%0d pc=%h v=%b exp cnt=2 pc=00000100 v=1", skid_count, out_pc, out_valid); end
    stall = 1'b0; step();
    checks++; if (out_pc !== 32'h104 || skid_count !== 2'd1) begin
      errors++; $display("FAIL drain1 got pc=%h cnt=%0d exp pc=00000104 cnt=1", out_pc, skid_count); end
    step();
    checks++; if (out_pc !== 32'h108 || out_ins !== ins_of(32'h108) || skid_count !== 2'd1) begin
      errors++; $display("FAIL drain2 got pc=%h ins=%h cnt=%0d exp pc=00000108 cnt=1", out_pc, out_ins, skid_count); end
    drive(1'b0, 32'h0); step();
    checks++; if (out_pc !== 32'h10C || out_ins !== ins_of(32'h10C) || out_valid !== 1'b1 || skid_count !== 2'd0) begin
      errors++; $display("FAIL drain3 got pc=%h ins=%h v=%b cnt=%0d exp pc=0000010c v=1 cnt=0", out_pc, out_ins, out_valid, skid_count); end
  endtask

  task automatic test_flush_vs_stall();
    stall = 1'b1;
    drive(1'b1, 32'h110); step();
    drive(1'b1, 32'h114); step();
    checks++; if (skid_count !== 2'd2) begin errors++; $display("FAIL flush_setup_cnt got=%0d exp=2", skid_count); end
    drive(1'b1, 32'h200); flush = 1'b1; step();
    checks++; if (out_valid !== 1'b0 || out_ins !== 32'h13 || skid_count !== 2'd0 || out_pc !== 32'h10C) begin
      errors++; $display("FAIL flush_over_stall got v=%b ins=%h cnt=%0d pc=%h exp v=0 ins=00000013 cnt=0 pc=0000010c", out_valid, out_ins, skid_count, out_pc); end
    flush = 1'b0; stall = 1'b0;
    drive(1'b0, 32'h0);
  endtask

  task automatic test_bubble();
    step();
    checks++; if (out_valid !== 1'b0 || out_ins !== 32'h13 || out_pc !== 32'h10C || in_ready !== 1'b1) begin
      errors++; $display("FAIL bubble got v=%b ins=%h pc=%h rdy=%b exp v=0 ins=00000013 pc=0000010c rdy=1", out_valid, out_ins, out_pc, in_ready); end
    drive(1'b1, 32'h300); step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_ins !== ins_of(32'h300)) begin
      errors++; $display("FAIL after_bubble got v=%b pc=%h ins=%h exp v=1 pc=00000300", out_valid, out_pc, out_ins); end
    drive(1'b0, 32'h0); step();
  endtask

  task automatic test_ptr_wrap();
    int  i = 0;
    int  j = 0;
    bit  pushed;
    for (int cyc = 0; cyc < 200 && j < 20; cyc++) begin
      stall2    = (cyc % 2 == 0);
      in_valid2 = (i < 20);
      in_pc2    = 32'(i * 4);
      in_ins2   = ins_of(32'(i * 4));
      pushed    = in_valid2 && in_ready2;
      step();
      if (pushed) i++;
      if (!stall2 && out_valid2) begin
        checks++;
        if (out_pc2 !== 32'(j * 4) || out_ins2 !== ins_of(32'(j * 4))) begin
          errors++; $display("FAIL wrap_order idx=%0d got pc=%h ins=%h exp pc=%h", j, out_pc2, out_ins2, 32'(j * 4)); end
        j++;
      end
      checks++;
      if (skid_count2 > 3'd4) begin errors++; $display("FAIL wrap_count got=%0d exp<=4", skid_count2); end
    end
    in_valid2 = 1'b0; stall2 = 1'b0;
    checks++; if (j != 20) begin errors++; $display("FAIL wrap_total got=%0d exp=20", j); end
  endtask

`ifdef IF_ID_SKID_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; drive(1'b0, 32'h0);
    step();
    checks++; if (stall_cycles !== 32'd0 || bubble_cycles !== 32'd0 || flush_count !== 16'd0) begin
      errors++; $display("FAIL perf_reset0 got s=%0d b=%0d f=%0d exp 0 0 0", stall_cycles, bubble_cycles, flush_count); end
    rst_n = 1'b1;
    drive(1'b1, 32'h400); step();           // one bubble edge (out_valid was 0)
    drive(1'b0, 32'h0); stall = 1'b1;
    repeat (5) step();                      // five stalled valid cycles
    stall = 1'b0;
    repeat (4) step();                      // first edge drops valid, then three bubbles
    flush = 1'b1;
    repeat (2) step();                      // two flushes, also bubbles
    flush = 1'b0;
    checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL perf_stall got=%0d exp=5", stall_cycles); end
    checks++; if (bubble_cycles !== 32'd6) begin errors++; $display("FAIL perf_bubble got=%0d exp=6", bubble_cycles); end
    checks++; if (flush_count !== 16'd2) begin errors++; $display("FAIL perf_flush got=%0d exp=2", flush_count); end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    checks++; if (stall_cycles !== 32'd0 || bubble_cycles !== 32'd0 || flush_count !== 16'd0) begin
      errors++; $display("FAIL perf_reset1 got s=%0d b=%0d f=%0d exp 0 0 0", stall_cycles, bubble_cycles, flush_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_stall_queue();
    test_flush_vs_stall();
    test_bubble();
    test_ptr_wrap();
`ifdef IF_ID_SKID_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
